// File: rtl/uart_disp_sched_if.sv
// Byte-strobe input and multiplexed seven-segment output bundle for uart_disp_sched.
interface uart_disp_sched_if;
   logic       valid;
   logic [7:0] data;
   logic [7:0] led_en;
   logic [7:0] led_cx;

   modport master (output valid, output data, input led_en, input led_cx);
   modport slave  (input valid, input data, output led_en, output led_cx);
endinterface

// File: rtl/uart_disp_sched.sv
// Round-robin owner of the 8-digit seven-segment display: ID, last byte, hex and BCD byte counts.
// Optional RX_FLASH_EN: DP on DK4 flashes for FLASH_MS after each received byte.
module uart_disp_sched #(
   parameter int       CLK_FREQ = 100000000,
   parameter int       SCAN_HZ  = 1000,
   parameter bit [3:0] ID_HI    = 4'd0,
   parameter bit [3:0] ID_LO    = 4'd9,
   parameter int       FLASH_MS = 50
) (
   input logic              clk,
   input logic              rst,
   uart_disp_sched_if.slave bus
);
   localparam int             DIV    = CLK_FREQ / SCAN_HZ;
   localparam int             CW     = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] DIV_M1 = CW'(DIV - 1);

   logic [CW-1:0] dwell;
   logic [2:0]    idx;
   logic          run;
   logic [7:0]    last_byte;
   logic [7:0]    hex_cnt;
   logic [3:0]    dec_tens;
   logic [3:0]    dec_ones;
   logic [3:0]    nib;
   logic [7:0]    seg_cur;
   logic          dp;
   logic          tick;

   function automatic logic [7:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 8'h03;
         4'h1: seg7 = 8'h9F;
         4'h2: seg7 = 8'h25;
         4'h3: seg7 = 8'h0D;
         4'h4: seg7 = 8'h99;
         4'h5: seg7 = 8'h49;
         4'h6: seg7 = 8'h41;
         4'h7: seg7 = 8'h1F;
         4'h8: seg7 = 8'h01;
         4'h9: seg7 = 8'h09;
         4'hA: seg7 = 8'h11;
         4'hB: seg7 = 8'hC1;
         4'hC: seg7 = 8'h63;
         4'hD: seg7 = 8'h85;
         4'hE: seg7 = 8'h61;
         default: seg7 = 8'h71;
      endcase
   endfunction

   assign tick = (dwell == DIV_M1);

   // run stays low until the first tick so the scan starts on DK0 a full dwell after reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         dwell <= '0;
         idx   <= 3'd0;
         run   <= 1'b0;
      end else if (tick) begin
         dwell <= '0;
         run   <= 1'b1;
         if (run)
            idx <= idx + 3'd1;
      end else begin
         dwell <= dwell + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_byte <= 8'h00;
         hex_cnt   <= 8'h00;
         dec_tens  <= 4'd0;
         dec_ones  <= 4'd0;
      end else if (bus.valid) begin
         last_byte <= bus.data;
         hex_cnt   <= hex_cnt + 8'd1;
         if (dec_ones == 4'd9) begin
            dec_ones <= 4'd0;
            dec_tens <= (dec_tens == 4'd9) ? 4'd0 : dec_tens + 4'd1;
         end else begin
            dec_ones <= dec_ones + 4'd1;
         end
      end
   end

`ifdef RX_FLASH_EN
   localparam longint FLASH_LEN = longint'(FLASH_MS) * longint'(CLK_FREQ) / 1000;
   localparam int     FW        = $clog2(FLASH_LEN + 1);
   logic [FW-1:0] flash;

   always_ff @(posedge clk) begin
      if (rst)
         flash <= '0;
      else if (bus.valid)
         flash <= FW'(FLASH_LEN);
      else if (flash != '0)
         flash <= flash - FW'(1);
   end

   assign dp = !((flash != '0) && (idx == 3'd4));
`else
   assign dp = 1'b1;
`endif

   always_comb begin
      nib = 4'h0;
      case (idx)
         3'd7: nib = ID_HI;
         3'd6: nib = ID_LO;
         3'd5: nib = last_byte[7:4];
         3'd4: nib = last_byte[3:0];
         3'd3: nib = hex_cnt[7:4];
         3'd2: nib = hex_cnt[3:0];
         3'd1: nib = dec_tens;
         default: nib = dec_ones;
      endcase
      seg_cur = seg7(nib);
   end

   always_ff @(posedge clk) begin
      if (rst || !run) begin
         bus.led_en <= 8'hFF;
         bus.led_cx <= 8'hFF;
      end else begin
         bus.led_en <= ~(8'b1 << idx);
         bus.led_cx <= {seg_cur[7:1], dp};
      end
   end
endmodule

// File: tb/tb_uart_disp_sched.sv
// Randomized bench for uart_disp_sched against an arithmetic model of the display schedule.
module tb_uart_disp_sched;
   localparam int       CLK_FREQ = 1000;
   localparam int       SCAN_HZ  = 250;
   localparam int       DIV      = CLK_FREQ / SCAN_HZ;
   localparam bit [3:0] ID_HI    = 4'd0;
   localparam bit [3:0] ID_LO    = 4'd9;
   localparam int       FLASH_MS = 50;
   localparam int       FLASH_LEN = FLASH_MS * CLK_FREQ / 1000;
`ifdef RX_FLASH_EN
   localparam bit       FLASH_ON = 1'b1;
`else
   localparam bit       FLASH_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   uart_disp_sched_if bus ();

   uart_disp_sched #(
      .CLK_FREQ(CLK_FREQ), .SCAN_HZ(SCAN_HZ), .ID_HI(ID_HI), .ID_LO(ID_LO), .FLASH_MS(FLASH_MS)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

   int n_checks = 0;
   int n_errors = 0;

   // Model: k = edges since the reset edge; fields as byte totals since reset.
   int         k = 0;
   int         cnt = 0, pcnt = 0;
   int         vedge = 0, pvedge = 0;
   bit         hv = 1'b0, phv = 1'b0;
   logic [7:0] last = 8'h00, plast = 8'h00;
   bit         was_rst = 1'b1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s observed %h expected %h (edge %0d)", tag, obs, exp, k);
      end
   endtask

   // Digit shown after edge kk (-1 when blank).
   function automatic int shown_idx(input int kk);
      int t;
      t = kk / DIV;
      return (t == 0) ? -1 : (t - 1) % 8;
   endfunction

   task automatic step(input logic v, input logic [7:0] d, input logic r);
      logic [7:0] exp_en, exp_cx;
      logic [3:0] n;
      int         di;
      bus.valid = v;
      bus.data  = d;
      rst       = r;
      @(posedge clk);
      if (r) begin
         k = 0; cnt = 0; pcnt = 0; vedge = 0; pvedge = 0;
         hv = 1'b0; phv = 1'b0; last = 8'h00; plast = 8'h00;
         was_rst = 1'b1;
      end else begin
         pcnt = cnt; plast = last; pvedge = vedge; phv = hv;
         k++;
         was_rst = 1'b0;
         if (v) begin
            cnt++;
            last  = d;
            vedge = k;
            hv    = 1'b1;
         end
      end
      @(negedge clk);
      di = was_rst ? -1 : shown_idx(k - 1);
      if (di < 0) begin
         exp_en = 8'hFF;
         exp_cx = 8'hFF;
      end else begin
         case (di)
            7: n = ID_HI;
            6: n = ID_LO;
            5: n = plast[7:4];
            4: n = plast[3:0];
            3: n = 4'((pcnt % 256) / 16);
            2: n = 4'(pcnt % 16);
            1: n = 4'((pcnt % 100) / 10);
            default: n = 4'(pcnt % 10);
         endcase
         exp_en = ~(8'b1 << di);
         exp_cx = seg_tab[n];
         if (FLASH_ON && di == 4 && phv && ((k - 1 - pvedge) < FLASH_LEN))
            exp_cx[0] = 1'b0;
      end
      chk("led_en", {24'h0, bus.led_en}, {24'h0, exp_en});
      chk("led_cx", {24'h0, bus.led_cx}, {24'h0, exp_cx});
      chk("onehot", 32'($countones(~bus.led_en) <= 1), 32'd1);
   endtask

   initial begin
      bus.valid = 1'b0;
      bus.data  = 8'h00;
      step(1'b0, 8'h00, 1'b1);
      step(1'b0, 8'h00, 1'b1);
      // Idle scan: ID and zero counts.
      for (int i = 0; i < 40; i++) step(1'b0, 8'($urandom), 1'b0);
      // Single byte A5.
      step(1'b1, 8'hA5, 1'b0);
      for (int i = 0; i < 40; i++) step(1'b0, 8'($urandom), 1'b0);
      // 100 back-to-back bytes (valid held high).
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 100; i++) step(1'b1, 8'($urandom), 1'b0);
      for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b0);
      // 256 pulses with random spacing.
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 256; i++) begin
         step(1'b1, 8'($urandom), 1'b0);
         for (int j = $urandom_range(0, 2); j > 0; j--) step(1'b0, 8'($urandom), 1'b0);
      end
      for (int i = 0; i < 40; i++) step(1'b0, 8'h00, 1'b0);
      // Reset in the middle of the DK3 dwell.
      for (int i = 0; i < 64; i++) begin
         if (k >= DIV && shown_idx(k) == 3 && (k % DIV) == 1) break;
         step(1'b0, 8'h00, 1'b0);
      end
      chk("dk3_phase", 32'(shown_idx(k)), 32'd3);
      step(1'b0, 8'h00, 1'b1);
      for (int i = 0; i < 20; i++) step(1'b0, 8'h00, 1'b0);
      // Byte 3C on the same edge as the tick into DK4.
      for (int i = 0; i < 64; i++) begin
         if (((k + 1) % DIV) == 0 && shown_idx(k + 1) == 4) break;
         step(1'b0, 8'h00, 1'b0);
      end
      chk("dk4_phase", 32'(shown_idx(k + 1)), 32'd4);
      step(1'b1, 8'h3C, 1'b0);
      for (int i = 0; i < 120; i++) step(1'b0, 8'h00, 1'b0);
      // Random traffic with rare resets.
      for (int i = 0; i < 3000; i++)
         step($urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 499) == 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
